// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divide unit: op and state
// encodings, special-case constants and small operand helpers.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // Signed ops are the ones with op[0] clear (DIV, REM).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder.
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

    // Magnitude of a value, interpreted as signed only when en is set.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring-division step. Shifts the next dividend bit into
// the partial remainder, trial-subtracts the divisor and restores on borrow.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            quo_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o,
    output logic            borrow_o
);

    logic [XLEN-1:0] partial;
    logic            partial_msb;
    logic [XLEN-1:0] trial;
    logic            carry;

    assign partial     = {rem_i[XLEN-2:0], quo_msb_i};
    // Bit 32 of the shifted remainder; it can be set when the divisor is
    // above 2^31, and then the 33-bit partial always exceeds the divisor.
    assign partial_msb = rem_i[XLEN-1];

    dsp_add_sub u_add_sub (
        .a_i     (partial),
        .b_i     (divisor_i),
        .sub_i   (1'b1),
        .sum_o   (trial),
        .carry_o (carry)
    );

    // Keep the difference unless the 33-bit compare says it went negative.
    always_comb begin
        borrow_o = ~(partial_msb | carry);
        q_bit_o  = ~borrow_o;
        rem_o    = borrow_o ? partial : trial;
    end

endmodule

// File: rtl/dsp_add_sub.sv
// 32-bit adder/subtractor. With sub_i set it computes a_i - b_i as
// a_i + ~b_i + 1; carry_o is then the no-borrow flag.
module dsp_add_sub (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic [31:0] sum_o,
    output logic        carry_o
);

    logic [31:0] b_eff;

    // Invert b and inject the carry-in for subtraction.
    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, sub_i};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU), radix-2 restoring,
// one trial subtraction per cycle. Define DIV_EARLY_OUT_EN to let divide
// by zero and signed overflow bypass the iteration phase.
module iter_divider
    import div_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic            is_rem_q, is_rem_d;
    logic            quot_neg_q, quot_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    logic            accept;
    logic            in_signed;
    logic            in_zero;
    logic            in_ovf;
    logic [XLEN-1:0] step_rem;
    logic            step_qbit;
    logic            step_borrow;
    logic            unused_borrow;
    logic [XLEN-1:0] fix_quot;
    logic [XLEN-1:0] fix_rem;
    logic [XLEN-1:0] fix_result;

    // The done cycle still counts as busy, so a start there is not accepted.
    assign accept    = (state_q == ST_IDLE) && !done_q && start_i && !flush_i;
    assign in_signed = op_is_signed(op_i);
    assign in_zero   = (divisor_i == '0);
    assign in_ovf    = in_signed && (dividend_i == INT_MIN) && (divisor_i == '1);

    assign unused_borrow = step_borrow;

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_i     (rem_q),
        .quo_msb_i (quo_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit),
        .borrow_o  (step_borrow)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                        state_d = (in_zero || in_ovf) ? ST_FIX : ST_CALC;
`else
                        state_d = ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Final sign fix and special-case override, consumed in ST_FIX.
    always_comb begin
        fix_quot = quot_neg_q ? (~quo_q + 1'b1) : quo_q;
        fix_rem  = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
        if (div_zero_q) begin
            fix_quot = DIV_ZERO_QUOT;
            fix_rem  = dvd_q;
        end else if (ovf_q) begin
            fix_quot = INT_MIN;
            fix_rem  = '0;
        end
        fix_result = is_rem_q ? fix_rem : fix_quot;
    end

    // Datapath next-state: operand capture, iteration and result register.
    always_comb begin
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        is_rem_d   = is_rem_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        done_d     = 1'b0;
        if (!flush_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        quo_d      = abs32(dividend_i, in_signed);
                        rem_d      = '0;
                        dvs_d      = abs32(divisor_i, in_signed);
                        dvd_d      = dividend_i;
                        is_rem_d   = op_is_rem(op_i);
                        quot_neg_d = in_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        rem_neg_d  = in_signed && dividend_i[XLEN-1];
                        div_zero_d = in_zero;
                        ovf_d      = in_ovf;
                        cnt_d      = CntLast;
                    end
                end
                ST_CALC: begin
                    rem_d = step_rem;
                    quo_d = {quo_q[XLEN-2:0], step_qbit};
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_FIX: begin
                    result_d = fix_result;
                    done_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dvd_q      <= '0;
            is_rem_q   <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
            is_rem_q   <= is_rem_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    // Outputs: busy covers the iteration, the fix cycle and the done cycle.
    always_comb begin
        busy_o   = (state_q != ST_IDLE) || done_q;
        done_o   = done_q;
        result_o = result_q;
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider.
module tb_iter_divider;
    import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int SpecLat = 2;
`else
    localparam int SpecLat = 34;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_tests;
    int n_fail;
    int lat;
    int done_seen;

    iter_divider u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .op_i       (op),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .flush_i    (flush),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // At the next falling edge (cycle 0) check idle and present a start.
    task automatic begin_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
    endtask

    // Wait for done, counting cycles from the start cycle. inj>0 pulses a
    // competing start with other operands in that cycle.
    task automatic wait_done(input string tag, input int inj);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
            end
            if (inj > 0 && lat == inj) begin
                start    = 1'b1;
                op       = OP_DIVU;
                dividend = 32'd1000;
                divisor  = 32'd3;
            end
            if (inj > 0 && lat == inj + 1) start = 1'b0;
        end while (!done && lat < 100);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        begin_op(tag, o, a, b);
        wait_done(tag, 0);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result, exp);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = OP_DIV;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;

        // Basic unsigned, then back-to-back ops (each starts the cycle after done).
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        // Divisor above 2^31 exercises the 33-bit compare.
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34);
        run_op("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34);

        // Special cases.
        run_op("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SpecLat);
        run_op("rem_by0", OP_REM, 32'h1234_5678, 32'd0, 32'h1234_5678, SpecLat);
        run_op("div_by0_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SpecLat);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpecLat);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SpecLat);
        run_op("divu_not_ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

        // Establish a known previous result, then flush in cycle 10.
        run_op("pre_flush", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        begin_op("flush", OP_DIVU, 32'd200, 32'd7);
        done_seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done) done_seen++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_nodone", 32'(done_seen) + {31'd0, done}, 32'd0);
        chk("flush_hold", result, 32'd14);
        // Start in cycle 12; done 34 cycles later, in cycle 46.
        run_op("after_flush", OP_DIVU, 32'd200, 32'd7, 32'd28, 34);

        // Start while busy is ignored.
        begin_op("ign", OP_DIVU, 32'd100, 32'd7);
        wait_done("ign", 5);
        chk("ign_lat", 32'(lat), 32'd34);
        chk("ign_res", result, 32'd14);

        // Flush together with start in IDLE: start is dropped.
        @(negedge clk);
        start    = 1'b1;
        flush    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd9;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flstart_busy", {31'd0, busy}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("flstart_nodone", 32'(done_seen), 32'd0);
        chk("flstart_hold", result, 32'd14);

        // Asynchronous reset mid-CALC.
        begin_op("rst_mid", OP_DIVU, 32'd100, 32'd7);
        repeat (10) @(negedge clk) start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_done", {31'd0, done}, 32'd0);
        chk("rstmid_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
